// File: rtl/exec_if.sv
// exec_if: issue/write-back bundle between the register-file read stage and the execute unit
interface exec_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              start;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] rd_addr_in;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              busy;
  logic              done;
  logic              write_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              zero_flag;
  logic              carry_flag;
  modport master (
    output start, opcode, rd_addr_in, rs1_data, rs2_data,
    input  busy, done, write_enable, rd_addr, rd_data, zero_flag, carry_flag
  );
  modport slave (
    input  start, opcode, rd_addr_in, rs1_data, rs2_data,
    output busy, done, write_enable, rd_addr, rd_data, zero_flag, carry_flag
  );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: single-cycle ALU ops plus iterative shift-add MUL and restoring DIV with a one-cycle write-back pulse
module exec_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input logic   clk,
  input logic   rst_n,
  exec_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                         OP_MUL = 3'b100, OP_DIVQ = 3'b101, OP_DIVR = 3'b110, OP_NOP = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, we_q, zero_q, carry_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W:0]   sum_d, dif_d, rsh_d, rsub_d;
  logic [DATA_W-1:0] prod_d, rem_d, quo_d, imm_d, res_d;
  logic              imm_c_d, iter_d;
  // a_q is the multiplicand (MUL) or the dividend shifting into the quotient (DIV);
  // acc_q is the product accumulator (MUL) or the partial remainder (DIV)
  always_comb begin
    sum_d   = {1'b0, bus.rs1_data} + {1'b0, bus.rs2_data};
    dif_d   = {1'b0, bus.rs1_data} - {1'b0, bus.rs2_data};
    prod_d  = acc_q + (b_q[0] ? a_q : '0);
    rsh_d   = {acc_q, a_q[DATA_W-1]};
    rsub_d  = rsh_d - {1'b0, b_q};
    rem_d   = rsub_d[DATA_W] ? rsh_d[DATA_W-1:0] : rsub_d[DATA_W-1:0];
    quo_d   = {a_q[DATA_W-2:0], ~rsub_d[DATA_W]};
    res_d   = op_q == OP_MUL ? prod_d : op_q == OP_DIVQ ? quo_d : rem_d;
    imm_d   = bus.opcode == OP_ADD  ? sum_d[DATA_W-1:0] :
              bus.opcode == OP_SUB  ? dif_d[DATA_W-1:0] :
              bus.opcode == OP_AND  ? bus.rs1_data & bus.rs2_data :
              bus.opcode == OP_OR   ? bus.rs1_data | bus.rs2_data :
              bus.opcode == OP_DIVQ ? '1 :
              bus.opcode == OP_DIVR ? bus.rs1_data : '0;
    imm_c_d = bus.opcode == OP_ADD ? sum_d[DATA_W] : bus.opcode == OP_SUB ? dif_d[DATA_W] : 1'b0;
    iter_d  = bus.opcode == OP_MUL ||
              ((bus.opcode == OP_DIVQ || bus.opcode == OP_DIVR) && bus.rs2_data != '0);
  end
  // control FSM with registered outputs; results land in the output registers only when entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.opcode;
            addr_q <= bus.rd_addr_in;
            a_q    <= bus.rs1_data;
            b_q    <= bus.rs2_data;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (iter_d) begin
              state_q <= RUN;
            end else begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              we_q      <= bus.opcode != OP_NOP;
              rd_addr_q <= bus.rd_addr_in;
              rd_data_q <= imm_d;
              zero_q    <= imm_d == '0;
              carry_q   <= imm_c_d;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q == OP_MUL) begin
            acc_q <= prod_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= rem_d;
            a_q   <= quo_d;
          end
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            we_q      <= 1'b1;
            rd_addr_q <= addr_q;
            rd_data_q <= res_d;
            zero_q    <= res_d == '0;
            carry_q   <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.write_enable = we_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.zero_flag    = zero_q;
  assign bus.carry_flag   = carry_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: table-driven directed vectors plus hand sequences for start-during-RUN and mid-op reset
module tb_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] prev_data = '0;
  logic had_op = 1'b0;
  exec_if #(.DATA_W(16), .ADDR_W(2)) bus ();
  exec_unit #(.DATA_W(16), .ADDR_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        z;
    logic        c;
    logic        we;
    int          lat;
    logic        cd;
  } vec_t;
  vec_t v[18];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] op, input logic [1:0] rd, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic ez, input logic ec, input logic ewe,
                        input int elat, input logic cd, input logic pulse);
    int cyc;
    logic busy_bad;
    @(negedge clk);
    if (had_op) chk("done_one_cycle", bus.done, 1'b0);
    bus.start = 1'b1; bus.opcode = op; bus.rd_addr_in = rd; bus.rs1_data = a; bus.rs2_data = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    busy_bad = 1'b0;
    chk("busy_c1", bus.busy, 1'b1);
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy) busy_bad = 1'b1;
      if (cyc == 5) chk("hold_rd_data", bus.rd_data, prev_data);
      bus.start = pulse && cyc >= 3 && cyc <= 6;
      bus.opcode = 3'b000; bus.rd_addr_in = 2'd0; bus.rs1_data = 16'h1111; bus.rs2_data = 16'h2222;
    end
    bus.start = 1'b0;
    if (elat > 1) chk("busy_run", busy_bad, 1'b0);
    chk("latency", cyc, elat);
    chk("done", bus.done, 1'b1);
    chk("write_enable", bus.write_enable, ewe);
    if (cd) begin
      chk("rd_addr", bus.rd_addr, rd);
      chk("rd_data", bus.rd_data, ed);
      chk("zero_flag", bus.zero_flag, ez);
      chk("carry_flag", bus.carry_flag, ec);
      prev_data = ed;
    end else begin
      prev_data = bus.rd_data;
    end
    had_op = 1'b1;
  endtask
  initial begin
    int cyc;
    logic seen;
    bus.start = 1'b0; bus.opcode = 3'b111; bus.rd_addr_in = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    v[0]  = '{3'b000, 2'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 1,  1'b1};
    v[1]  = '{3'b001, 2'd2, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1,  1'b1};
    v[2]  = '{3'b010, 2'd3, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b1, 1,  1'b1};
    v[3]  = '{3'b011, 2'd0, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b1, 1,  1'b1};
    v[4]  = '{3'b000, 2'd1, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b1, 1,  1'b1};
    v[5]  = '{3'b001, 2'd2, 16'h0007, 16'h0005, 16'h0002, 1'b0, 1'b0, 1'b1, 1,  1'b1};
    v[6]  = '{3'b001, 2'd3, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1,  1'b1};
    v[7]  = '{3'b100, 2'd3, 16'h012C, 16'h012C, 16'h5F90, 1'b0, 1'b0, 1'b1, 17, 1'b1};
    v[8]  = '{3'b100, 2'd1, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 17, 1'b1};
    v[9]  = '{3'b100, 2'd2, 16'h0000, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 17, 1'b1};
    v[10] = '{3'b101, 2'd1, 16'h03E8, 16'h0007, 16'h008E, 1'b0, 1'b0, 1'b1, 17, 1'b1};
    v[11] = '{3'b110, 2'd2, 16'h03E8, 16'h0007, 16'h0006, 1'b0, 1'b0, 1'b1, 17, 1'b1};
    v[12] = '{3'b101, 2'd3, 16'h04D2, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1,  1'b1};
    v[13] = '{3'b110, 2'd0, 16'h04D2, 16'h0000, 16'h04D2, 1'b0, 1'b0, 1'b1, 1,  1'b1};
    v[14] = '{3'b101, 2'd1, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 17, 1'b1};
    v[15] = '{3'b110, 2'd2, 16'h000E, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b1, 17, 1'b1};
    v[16] = '{3'b111, 2'd3, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1,  1'b0};
    v[17] = '{3'b110, 2'd3, 16'h0005, 16'h0009, 16'h0005, 1'b0, 1'b0, 1'b1, 17, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_we", bus.write_enable, 1'b0);
    chk("rst_rd_data", bus.rd_data, 16'h0000);
    chk("rst_flags", {bus.zero_flag, bus.carry_flag, bus.rd_addr}, 4'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++)
      run_op(v[i].op, v[i].rd, v[i].a, v[i].b, v[i].d, v[i].z, v[i].c, v[i].we, v[i].lat, v[i].cd, 1'b0);
    run_op(3'b100, 2'd3, 16'd300, 16'd300, 16'h5F90, 1'b0, 1'b0, 1'b1, 17, 1'b1, 1'b1);
    run_op(3'b111, 2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 3'b100; bus.rd_addr_in = 2'd2; bus.rs1_data = 16'd3; bus.rs2_data = 16'd4;
    @(negedge clk);
    bus.start = 1'b0;
    for (cyc = 1; cyc < 8; cyc++) @(negedge clk);
    chk("busy_before_rst", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_outs", {bus.done, bus.write_enable, bus.zero_flag, bus.carry_flag, bus.rd_addr, bus.rd_data}, 22'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done || bus.write_enable || bus.busy) seen = 1'b1;
    end
    chk("no_done_after_abort", seen, 1'b0);
    prev_data = 16'h0000;
    had_op = 1'b0;
    run_op(3'b100, 2'd2, 16'd7, 16'd9, 16'h003F, 1'b0, 1'b0, 1'b1, 17, 1'b1, 1'b0);
    @(negedge clk);
    chk("final_idle", {bus.busy, bus.done}, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
